// File: rtl/packet_output_arbiter_pkg.sv
// Shared switch definitions for the output arbiter: state encoding,
// grant-index width derivation and default sizing.
package packet_output_arbiter_pkg;

    // Arbiter state encoding (kept as plain constants for legacy users)
    localparam logic [0:0] ARB_IDLE = 1'b0;
    localparam logic [0:0] ARB_BUSY = 1'b1;

    // Default number of competing input ports (N, S, E, W, local)
    localparam int ARB_IN_N_DEFAULT = 5;

    // Default stall limit before a held grant is forcibly released
    localparam int ARB_TIMEOUT_CYCLES_DEFAULT = 64;

    // Width of an encoded index into n ports; never narrower than one bit
    function automatic int arb_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/packet_output_arbiter_rr_priority_picker.sv
// Combinational round-robin priority picker. The request vector is doubled,
// rotated right by the pointer and scanned from bit 0, so the first set bit
// at or after ptr wins (with wrap). Shared with the input-side VC allocator.
module rr_priority_picker
    import packet_output_arbiter_pkg::*;
#(
    parameter int N     = ARB_IN_N_DEFAULT,
    parameter int IDX_W = arb_idx_w(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic             found,
    output logic [IDX_W-1:0] winner,
    output logic [N-1:0]     winner_onehot
);

    logic [2*N-1:0]   req_dbl;
    logic [2*N-1:0]   req_shifted;
    logic [N-1:0]     req_rot;
    logic [IDX_W-1:0] offset;
    logic [IDX_W:0]   sum_raw;
    logic [IDX_W:0]   sum_wrap;

    assign req_dbl     = {req, req};
    assign req_shifted = req_dbl >> ptr;
    assign req_rot     = req_shifted[N-1:0];

    // Scan the rotated vector; descending loop leaves the lowest set offset
    always_comb begin
        offset = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                offset = IDX_W'(i);
            end
        end
    end

    // Undo the rotation: winner = (ptr + offset) mod N
    always_comb begin
        sum_raw  = {1'b0, ptr} + {1'b0, offset};
        sum_wrap = sum_raw;
        if (sum_raw >= (IDX_W + 1)'(N)) begin
            sum_wrap = sum_raw - (IDX_W + 1)'(N);
        end
    end

    assign found  = |req;
    assign winner = sum_wrap[IDX_W-1:0];

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_onehot
            assign winner_onehot[gi] = found && (winner == IDX_W'(gi));
        end
    endgenerate

endmodule

// File: rtl/packet_output_arbiter.sv
// Per-output-port wormhole arbiter for the NoC switch. A round-robin grant is
// registered and held from head to tail flit; on a tail transfer the next
// winner is chosen in the same cycle so packets hand over with no bubble.
// Optional feature macro: ARB_HOLD_TIMEOUT_EN (force-release of a grant that
// has been stalled for TIMEOUT_CYCLES cycles, reported on timeout_o).
module packet_output_arbiter
    import packet_output_arbiter_pkg::*;
#(
    parameter int IN_N = ARB_IN_N_DEFAULT
`ifdef ARB_HOLD_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = ARB_TIMEOUT_CYCLES_DEFAULT
`endif
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [IN_N-1:0]            req_i,
    input  logic                       flit_vld_i,
    input  logic                       flit_tail_i,
    input  logic                       out_rdy_i,
    output logic [IN_N-1:0]            gnt_o,
    output logic [arb_idx_w(IN_N)-1:0] gnt_idx_o,
    output logic                       gnt_vld_o,
    output logic                       xfer_o,
    output logic                       timeout_o
);

    localparam int IDX_W = arb_idx_w(IN_N);

    logic [0:0]       state_reg, state_next;
    logic [IN_N-1:0]  gnt_reg, gnt_next;
    logic [IDX_W-1:0] idx_reg, idx_next;
    logic [IDX_W-1:0] ptr_reg, ptr_next;   // round-robin highest-priority index

    logic             pick_found;
    logic [IDX_W-1:0] pick_idx;
    logic [IN_N-1:0]  pick_onehot;
    logic             timeout_fire;
    logic             release_grant;
    logic             arbitrate;

    rr_priority_picker #(
        .N     (IN_N),
        .IDX_W (IDX_W)
    ) u_picker (
        .req           (req_i),
        .ptr           (ptr_reg),
        .found         (pick_found),
        .winner        (pick_idx),
        .winner_onehot (pick_onehot)
    );

    assign gnt_vld_o = (state_reg == ARB_BUSY);
    assign xfer_o    = gnt_vld_o & flit_vld_i & out_rdy_i;
    assign gnt_o     = gnt_reg;
    assign gnt_idx_o = idx_reg;

`ifdef ARB_HOLD_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] stall_cnt_reg, stall_cnt_next;
    logic             timeout_reg;

    // Final stalled cycle: release now so the new grant and the pulse coincide
    assign timeout_fire = gnt_vld_o & ~xfer_o &
                          (stall_cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));

    // Count consecutive stalled BUSY cycles; any transfer or handover clears
    always_comb begin
        stall_cnt_next = stall_cnt_reg;
        if (!gnt_vld_o || xfer_o || timeout_fire) begin
            stall_cnt_next = '0;
        end else begin
            stall_cnt_next = stall_cnt_reg + 1'b1;
        end
    end

    // Stall counter and timeout pulse registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_cnt_reg <= '0;
            timeout_reg   <= 1'b0;
        end else begin
            stall_cnt_reg <= stall_cnt_next;
            timeout_reg   <= timeout_fire;
        end
    end

    assign timeout_o = timeout_reg;
`else
    assign timeout_fire = 1'b0;
    assign timeout_o    = 1'b0;
`endif

    assign release_grant = (xfer_o & flit_tail_i) | timeout_fire;
    assign arbitrate     = ~gnt_vld_o | release_grant;

    // Next grant: re-arbitrate when idle or releasing, otherwise hold
    always_comb begin
        state_next = state_reg;
        gnt_next   = gnt_reg;
        idx_next   = idx_reg;
        ptr_next   = ptr_reg;
        if (arbitrate) begin
            if (pick_found) begin
                state_next = ARB_BUSY;
                gnt_next   = pick_onehot;
                idx_next   = pick_idx;
                ptr_next   = (pick_idx == IDX_W'(IN_N - 1)) ? '0 : pick_idx + 1'b1;
            end else begin
                state_next = ARB_IDLE;
                gnt_next   = '0;
                idx_next   = '0;
            end
        end
    end

    // Grant, index, state and pointer registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg <= ARB_IDLE;
            gnt_reg   <= '0;
            idx_reg   <= '0;
            ptr_reg   <= '0;
        end else begin
            state_reg <= state_next;
            gnt_reg   <= gnt_next;
            idx_reg   <= idx_next;
            ptr_reg   <= ptr_next;
        end
    end

endmodule

// File: tb/tb_packet_output_arbiter.sv
// Directed testbench for packet_output_arbiter. Stimulus pushes the expected
// grant index of every new grant into a queue; a monitor pops and compares
// whenever the DUT presents a new grant.
module tb_packet_output_arbiter;

    localparam int N = 5;

    logic         clk_i = 1'b0;
    logic         rst_ni = 1'b0;
    logic [N-1:0] req_i = '0;
    logic         flit_vld_i = 1'b0;
    logic         flit_tail_i = 1'b0;
    logic         out_rdy_i = 1'b0;
    logic [N-1:0] gnt_o;
    logic [2:0]   gnt_idx_o;
    logic         gnt_vld_o;
    logic         xfer_o;
    logic         timeout_o;

    int checks = 0;
    int errors = 0;
    int exp_q[$];

    always #5 clk_i = ~clk_i;

`ifdef ARB_HOLD_TIMEOUT_EN
    packet_output_arbiter #(.IN_N(N), .TIMEOUT_CYCLES(8)) dut (
`else
    packet_output_arbiter #(.IN_N(N)) dut (
`endif
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .req_i       (req_i),
        .flit_vld_i  (flit_vld_i),
        .flit_tail_i (flit_tail_i),
        .out_rdy_i   (out_rdy_i),
        .gnt_o       (gnt_o),
        .gnt_idx_o   (gnt_idx_o),
        .gnt_vld_o   (gnt_vld_o),
        .xfer_o      (xfer_o),
        .timeout_o   (timeout_o)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
        end else begin
            $display("ok   %s value=%0d t=%0t", name, act, $time);
        end
    endtask

    // One cycle: drive inputs just after the rising edge, return mid-cycle
    task automatic cyc(input logic [N-1:0] r, input logic v, input logic t, input logic rd);
        @(posedge clk_i);
        #1;
        req_i       = r;
        flit_vld_i  = v;
        flit_tail_i = t;
        out_rdy_i   = rd;
        @(negedge clk_i);
    endtask

    // Monitor: a new grant is one that appears after idle, a tail transfer
    // or a forced release; each must match the next queued expectation
    logic prev_vld = 1'b0;
    logic prev_tail_xfer = 1'b0;
    initial begin
        forever begin
            @(negedge clk_i);
            if (gnt_vld_o && (!prev_vld || prev_tail_xfer || timeout_o)) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_grant", int'(gnt_idx_o), -1);
                end else begin
                    int e;
                    logic [N-1:0] oh;
                    e  = exp_q.pop_front();
                    oh = N'(1) << e;
                    check("grant_idx", int'(gnt_idx_o), e);
                    check("grant_onehot", int'(gnt_o), int'(oh));
                end
            end
            prev_vld       = gnt_vld_o;
            prev_tail_xfer = xfer_o && flit_tail_i;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state, with flit signals active while nothing is granted
        flit_vld_i  = 1'b1;
        flit_tail_i = 1'b1;
        out_rdy_i   = 1'b1;
        @(negedge clk_i);
        check("rst_gnt", int'(gnt_o), 0);
        check("rst_idx", int'(gnt_idx_o), 0);
        check("rst_vld", int'(gnt_vld_o), 0);
        check("rst_timeout", int'(timeout_o), 0);
        check("rst_xfer", int'(xfer_o), 0);
        @(posedge clk_i);
        #2 rst_ni = 1'b1;

        // First grant: req 10100, ptr 0 -> 2 one cycle later (ptr -> 3)
        exp_q.push_back(2);
        cyc(5'b10100, 1'b1, 1'b1, 1'b1);
        check("idle_vld", int'(gnt_vld_o), 0);
        check("idle_xfer_ignored", int'(xfer_o), 0);

        // 3-flit packet on input 2 with a 4-cycle backpressure gap
        cyc(5'b11111, 1'b1, 1'b0, 1'b1);
        check("pkt2_flit1_xfer", int'(xfer_o), 1);
        for (int i = 0; i < 4; i++) begin
            cyc(5'b11111, 1'b1, 1'b0, 1'b0);
            check("stall_hold_idx", int'(gnt_idx_o), 2);
            check("stall_xfer", int'(xfer_o), 0);
        end
        cyc(5'b11111, 1'b1, 1'b0, 1'b1);
        check("pkt2_flit2_xfer", int'(xfer_o), 1);
        exp_q.push_back(3);
        cyc(5'b11111, 1'b1, 1'b1, 1'b1);
        check("pkt2_tail_idx", int'(gnt_idx_o), 2);

        // Grant 3 single flit, req 10001 from ptr 4 -> 4; then wrap to 0
        exp_q.push_back(4);
        cyc(5'b10001, 1'b1, 1'b1, 1'b1);
        check("no_bubble_vld", int'(gnt_vld_o), 1);
        exp_q.push_back(0);
        cyc(5'b10001, 1'b1, 1'b1, 1'b1);
        check("grant4_xfer", int'(xfer_o), 1);

        // All inputs requesting single-flit packets: 1,2,3,4,0 from ptr 1
        exp_q.push_back(1);
        cyc(5'b11111, 1'b1, 1'b1, 1'b1);
        check("wrap_grant0_xfer", int'(xfer_o), 1);
        for (int k = 2; k <= 5; k++) begin
            exp_q.push_back(k % N);
            cyc(5'b11111, 1'b1, 1'b1, 1'b1);
            check("rr_xfer", int'(xfer_o), 1);
        end
        // Last single flit on input 0 with requests gone -> idle
        cyc(5'b00000, 1'b1, 1'b1, 1'b1);
        check("rr_last_idx", int'(gnt_idx_o), 0);
        cyc(5'b00000, 1'b0, 1'b0, 1'b1);
        check("back_to_idle", int'(gnt_vld_o), 0);

        // Reset in the middle of a 4-flit packet on input 2 (ptr is 1)
        exp_q.push_back(2);
        cyc(5'b00100, 1'b0, 1'b0, 1'b1);
        cyc(5'b00100, 1'b1, 1'b0, 1'b1);
        check("pre_rst_vld", int'(gnt_vld_o), 1);
        #1 rst_ni = 1'b0;
        #1;
        check("async_rst_vld", int'(gnt_vld_o), 0);
        check("async_rst_gnt", int'(gnt_o), 0);
        @(posedge clk_i);
        #1;
        req_i      = 5'b00010;
        flit_vld_i = 1'b0;
        rst_ni     = 1'b1;
        exp_q.push_back(1);
        @(negedge clk_i);
        check("post_rst_vld", int'(gnt_vld_o), 0);
        cyc(5'b00000, 1'b1, 1'b1, 1'b1);
        check("post_rst_xfer", int'(xfer_o), 1);
        cyc(5'b00000, 1'b0, 1'b0, 1'b1);
        check("post_rst_idle", int'(gnt_vld_o), 0);

        // Long stall on input 3 (ptr 2) while input 0 waits
        exp_q.push_back(3);
        cyc(5'b01000, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) begin
`ifdef ARB_HOLD_TIMEOUT_EN
            if (i == 7) exp_q.push_back(0);
`endif
            cyc(5'b00001, 1'b0, 1'b0, 1'b1);
            check("stall_timeout_low", int'(timeout_o), 0);
            check("stall_idx", int'(gnt_idx_o), 3);
        end
`ifdef ARB_HOLD_TIMEOUT_EN
        cyc(5'b00000, 1'b1, 1'b1, 1'b1);
        check("timeout_pulse", int'(timeout_o), 1);
`else
        exp_q.push_back(0);
        cyc(5'b00001, 1'b1, 1'b1, 1'b1);
        check("held_no_timeout", int'(timeout_o), 0);
        check("held_idx", int'(gnt_idx_o), 3);
        cyc(5'b00000, 1'b1, 1'b1, 1'b1);
`endif
        check("after_stall_idx", int'(gnt_idx_o), 0);
        cyc(5'b00000, 1'b0, 1'b0, 1'b1);
        check("final_idle", int'(gnt_vld_o), 0);
        check("final_timeout", int'(timeout_o), 0);
        check("queue_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
